// File: rtl/dram_arbiter.sv
// Two-port data RAM arbiter: fixed priority to the LSU (port 0),
// with a starvation counter that guarantees the debug/DMA port service.
module dram_arbiter #(
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [3:0]  p0_be,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdat,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [3:0]  p1_be,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdat,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        dram_we,
  output logic [3:0]  dram_we_byte,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdat,
  input  logic [31:0] dram_dout
);

  localparam logic [32:0] ADDR_END = 33'(DEPTH) * 33'd4;
  localparam logic [7:0]  LIMIT    = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt;
  logic        starved;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdat;
  logic        oor;
  logic [31:0] rsp_data;

  assign starved = starve_cnt == LIMIT;
  assign p0_gnt  = p0_req & ~(p1_req & starved);
  assign p1_gnt  = p1_req & ~p0_gnt;

  always_comb begin
    sel_we   = 1'b0;
    sel_be   = 4'h0;
    sel_addr = 32'h0;
    sel_wdat = 32'h0;
    unique case (1'b1)
      p0_gnt: begin
        sel_we   = p0_we;
        sel_be   = p0_be;
        sel_addr = p0_addr;
        sel_wdat = p0_wdat;
      end
      p1_gnt: begin
        sel_we   = p1_we;
        sel_be   = p1_be;
        sel_addr = p1_addr;
        sel_wdat = p1_wdat;
      end
      default: ;
    endcase
  end

  // Out-of-range accesses are still granted, but must never reach the RAM.
  assign oor          = {1'b0, sel_addr} >= ADDR_END;
  assign dram_we      = sel_we & ~oor;
  assign dram_we_byte = dram_we ? sel_be : 4'h0;
  assign dram_addr    = sel_addr;
  assign dram_wdat    = sel_wdat;

  assign rsp_data = (sel_we | oor) ? 32'h0 : dram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'h0;
    end else if (!p1_req || p1_gnt) begin
      starve_cnt <= 8'h0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 8'h1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= 32'h0;
      p0_err    <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt;
      if (p0_gnt) begin
        p0_rdata <= rsp_data;
        p0_err   <= oor;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_rvalid <= 1'b0;
      p1_rdata  <= 32'h0;
      p1_err    <= 1'b0;
    end else begin
      p1_rvalid <= p1_gnt;
      if (p1_gnt) begin
        p1_rdata <= rsp_data;
        p1_err   <= oor;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural byte-write RAM.
module tb_dram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [3:0]  p0_be;
  logic [31:0] p0_addr, p0_wdat, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [3:0]  p1_be;
  logic [31:0] p1_addr, p1_wdat, p1_rdata;
  logic        dram_we;
  logic [3:0]  dram_we_byte;
  logic [31:0] dram_addr, dram_wdat, dram_dout;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [0:1023];

  dram_arbiter #(.DEPTH(1024), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdat(p0_wdat), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdat(p1_wdat), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dram_we(dram_we), .dram_we_byte(dram_we_byte),
    .dram_addr(dram_addr), .dram_wdat(dram_wdat),
    .dram_dout(dram_dout)
  );

  always #5 clk = ~clk;

  assign dram_dout = mem[dram_addr[11:2]];

  // RAM contents are (re)loaded whenever reset is seen on a clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'hDEADBEEF;
      mem[8] <= 32'h11223344;
    end else if (dram_we) begin
      for (int b = 0; b < 4; b++)
        if (dram_we_byte[b])
          mem[dram_addr[11:2]][8*b +: 8] <= dram_wdat[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdat);
    p0_req = req; p0_we = we; p0_be = be; p0_addr = addr; p0_wdat = wdat;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdat);
    p1_req = req; p1_we = we; p1_be = be; p1_addr = addr; p1_wdat = wdat;
  endtask

  initial begin
    rst = 1'b1;
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    drv1(0, 0, 4'h0, 32'h0, 32'h0);
    tick;
    tick;
    check("rst_rv0", p0_rvalid, 0);
    check("rst_rd0", p0_rdata, 0);
    check("rst_err0", p0_err, 0);
    check("rst_rv1", p1_rvalid, 0);
    check("rst_rd1", p1_rdata, 0);
    check("idle_addr", dram_addr, 0);
    rst = 1'b0;

    // single read
    drv0(1, 0, 4'hF, 32'h14, 32'h0);
    #1;
    check("rd_gnt0", p0_gnt, 1);
    check("rd_gnt1", p1_gnt, 0);
    check("rd_addr", dram_addr, 32'h14);
    check("rd_we", dram_we, 0);
    check("rd_web", dram_we_byte, 0);
    tick;
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    check("rd_rv0", p0_rvalid, 1);
    check("rd_rdata", p0_rdata, 32'hDEADBEEF);
    check("rd_err", p0_err, 0);
    check("rd_rv1", p1_rvalid, 0);
    tick;
    check("rd_rv0_drop", p0_rvalid, 0);

    // byte write then read-after-write
    drv1(1, 1, 4'b0010, 32'h20, 32'h0000AB00);
    #1;
    check("wr_gnt1", p1_gnt, 1);
    check("wr_we", dram_we, 1);
    check("wr_web", dram_we_byte, 4'b0010);
    check("wr_wdat", dram_wdat, 32'h0000AB00);
    tick;
    drv1(1, 0, 4'hF, 32'h20, 32'h0);
    check("wr_rv1", p1_rvalid, 1);
    check("wr_rd1", p1_rdata, 0);
    check("wr_err1", p1_err, 0);
    #1;
    check("raw_web", dram_we_byte, 0);
    tick;
    check("raw_rv1", p1_rvalid, 1);
    check("raw_rd1", p1_rdata, 32'h1122AB44);

    // starvation: both held, 4:1 pattern
    drv0(1, 0, 4'h0, 32'h14, 32'h0);
    drv1(1, 0, 4'h0, 32'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("stv_gnt0", p0_gnt, 32'((k % 5) != 4));
      check("stv_gnt1", p1_gnt, 32'((k % 5) == 4));
      tick;
      check("stv_rv0", p0_rvalid, 32'((k % 5) != 4));
      check("stv_rv1", p1_rvalid, 32'((k % 5) == 4));
      if (k == 4) check("stv_rd1", p1_rdata, 32'h1122AB44);
    end
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    drv1(0, 0, 4'h0, 32'h0, 32'h0);

    // out of range write, and last in-range word
    drv0(1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    #1;
    check("oor_gnt0", p0_gnt, 1);
    check("oor_we", dram_we, 0);
    check("oor_web", dram_we_byte, 0);
    check("oor_addr", dram_addr, 32'h1000);
    tick;
    drv0(1, 0, 4'h0, 32'hFFC, 32'h0);
    check("oor_rv0", p0_rvalid, 1);
    check("oor_err", p0_err, 1);
    check("oor_rd0", p0_rdata, 0);
    check("oor_ram", mem[0], 0);
    tick;
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    check("edge_rv0", p0_rvalid, 1);
    check("edge_err", p0_err, 0);

    // alternating back-to-back reads
    drv0(1, 0, 4'h0, 32'h14, 32'h0);
    tick;
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    drv1(1, 0, 4'h0, 32'h20, 32'h0);
    check("alt_rv0", p0_rvalid, 1);
    check("alt_rd0", p0_rdata, 32'hDEADBEEF);
    check("alt_rv1_x", p1_rvalid, 0);
    tick;
    drv1(0, 0, 4'h0, 32'h0, 32'h0);
    check("alt_rv1", p1_rvalid, 1);
    check("alt_rd1", p1_rdata, 32'h1122AB44);
    check("alt_rv0_x", p0_rvalid, 0);
    check("alt_rd0_hold", p0_rdata, 32'hDEADBEEF);

    // reset during a p0 grant, with the starvation counter built up
    drv0(1, 0, 4'h0, 32'h14, 32'h0);
    drv1(1, 0, 4'h0, 32'h20, 32'h0);
    tick;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    check("mr_rv0_async", p0_rvalid, 0);
    check("mr_rd0_async", p0_rdata, 0);
    check("mr_gnt0", p0_gnt, 1);
    tick;
    check("mr_rv0", p0_rvalid, 0);
    rst = 1'b0;
    #1;
    check("mr_cnt_gnt0", p0_gnt, 1);
    check("mr_cnt_gnt1", p1_gnt, 0);
    drv1(0, 0, 4'h0, 32'h0, 32'h0);
    tick;
    drv0(0, 0, 4'h0, 32'h0, 32'h0);
    check("mr_rv0_re", p0_rvalid, 1);
    check("mr_rd0_re", p0_rdata, 32'hDEADBEEF);
    check("mr_rv1_re", p1_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-port arbiter that shares the single-ported data RAM (32-bit words, byte-write enables, combinational read) between the core load/store unit (port 0) and a debug/DMA master (port 1).
- Port 0 has fixed priority; an anti-starvation counter guarantees port 1 service.
- Each granted access gets a registered response one cycle later, with read data and an out-of-range error flag.
- Sits between the LSU/debug masters and the data RAM.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; valid byte addresses are 0 .. DEPTH*4-1.
- STARVE_LIMIT, 4, consecutive denied cycles of p1_req after which port 1 wins the next arbitration (range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 access request; held with payload stable until p0_gnt
- p0_we  in  1  1 = write, 0 = read
- p0_be  in  4  byte write enables (ignored for reads)
- p0_addr  in  32  byte address
- p0_wdat  in  32  write data
- p0_gnt  out  1  combinational grant; request consumed this cycle
- p0_rvalid  out  1  registered response strobe
- p0_rdata  out  32  registered read data
- p0_err  out  1  registered error, valid with p0_rvalid
- p1_req, p1_we, p1_be, p1_addr, p1_wdat, p1_gnt, p1_rvalid, p1_rdata, p1_err: identical to port 0
- dram_we  out  1  RAM write enable
- dram_we_byte  out  4  RAM byte enables
- dram_addr  out  32  RAM byte address
- dram_wdat  out  32  RAM write data
- dram_dout  in  32  RAM combinational read data for dram_addr

Behaviour:
- Arbitration is combinational each cycle; at most one grant per cycle.
  - Only p0_req: grant 0.
  - Only p1_req: grant 1.
  - Both requesting: grant 1 if starve_cnt == STARVE_LIMIT, else grant 0.
- starve_cnt (8-bit) updates on each rising edge:
  - Cleared when p1_req=0 or p1_gnt=1.
  - Otherwise incremented while below STARVE_LIMIT; it saturates there.
- Granted port drives the RAM in the same cycle: dram_addr=addr, dram_wdat=wdat, dram_we_byte=we?be:0, dram_we=we.
- Out-of-range access (addr >= DEPTH*4): granted as normal but dram_we and dram_we_byte forced to 0, so no RAM write occurs.
- No grant: dram_we=0, dram_we_byte=0, dram_addr=0, dram_wdat=0.
- Misaligned addr[1:0] is passed through unchanged; the RAM ignores bits [1:0]. Not an error.
- Response, registered on the edge ending the grant cycle, for the granted port only:
  - rvalid=1 for one cycle, for both reads and writes.
  - rdata = dram_dout sampled in the grant cycle for an in-range read; 0 for writes and errored accesses.
  - err = 1 for an out-of-range access, else 0.
  - The non-granted port gets rvalid=0; its rdata/err hold their previous values.
- Latency: request with gnt in cycle T -> response in cycle T+1. Back-to-back grants give one response per cycle.
- Read-after-write: a write granted in T followed by a read of the same word granted in T+1 returns the new data.
- No response backpressure: masters must accept rvalid when it arrives.
- Reset (asynchronous, any time): rvalid=0, rdata=0, err=0 on both ports; starve_cnt=0.
  - A grant that coincides with reset assertion produces no response; the master must reissue it.
  - Combinational outputs (gnt, dram_*) follow the inputs even during reset.
- Payload changes while req=1 and gnt=0 are a protocol violation; behaviour is undefined.

Test Plan:
- Single read: RAM word 5 = 0xDEADBEEF; p0 read addr 0x14 -> p0_gnt=1 in cycle T, dram_addr=0x14; p0_rvalid=1, p0_rdata=0xDEADBEEF, p0_err=0 in T+1.
- Byte write then read: p1 write addr 0x20, be=4'b0010, wdat=0x0000AB00 over word 0x11223344 -> dram_we_byte=0010; a read of 0x20 in the next cycle returns 0x1122AB44.
- Starvation: p0_req and p1_req both held high, STARVE_LIMIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4; counter clears and the pattern repeats (4:1).
- Out of range: p0 write addr 0x1000 (DEPTH=1024) -> p0_gnt=1, dram_we=0, dram_we_byte=0; next cycle p0_rvalid=1, p0_err=1, p0_rdata=0; RAM contents unchanged.
- Back-to-back alternating: p0 read then p1 read in consecutive cycles -> responses in consecutive cycles on the matching ports, no cross-port rvalid.
- Reset mid-operation: assert rst asynchronously during a p0 grant cycle -> p0_rvalid stays 0; after release, starve_cnt=0 (first contested cycle grants p0), and a reissued read completes normally.
